// File: rtl/sb_rx_packet_framer.sv
// sb_rx_packet_framer
//   Sideband RX framing stage in front of the sideband RX data decoder.
//   Classifies each deserialized 64-bit word as a header or a data phase,
//   registers it onto o_data and emits one-cycle strobes for the decoder.
//   Message-with-data packets (header followed by one data word) are tracked;
//   a header whose data word never arrives is timed out.
//
//   Optional feature macro: SB_RX_PARITY_CHECK_EN
//     defined   : header CP (bit 62) must equal ^word[61:0]; the data word
//                 must satisfy DP (header bit 63) == ^data[63:0].
//     undefined : CP/DP are ignored, no parity logic is built.
//
// Ports
//   i_clk, i_rst_n            clock, async active-low reset
//   i_word_valid, i_word      deserializer word strobe and word
//   o_data                    registered accepted word (holds otherwise)
//   o_header_is_valid_on_bus  accepted header on o_data (1-cycle pulse)
//   o_data_enable             accepted data word on o_data (1-cycle pulse)
//   o_msg_no_data             accepted header has no data phase (pulse)
//   o_busy                    waiting for the data phase of a packet
//   o_err_pulse               bad opcode / parity / timeout (pulse)
//   o_err_cnt                 saturating error count
module sb_rx_packet_framer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ERR_CNT_W      = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_word_valid,
  input  logic [63:0]          i_word,
  output logic [63:0]          o_data,
  output logic                 o_header_is_valid_on_bus,
  output logic                 o_data_enable,
  output logic                 o_msg_no_data,
  output logic                 o_busy,
  output logic                 o_err_pulse,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  localparam logic [4:0] OP_WITH_DATA = 5'b11011;
  localparam logic [4:0] OP_NO_DATA   = 5'b10010;
  localparam logic [7:0] TMO_LAST     = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, WAIT_DATA} state_t;

  state_t state, state_nxt;
  logic [7:0] tmo_cnt, tmo_cnt_nxt;

  logic is_with, is_no, tmo_hit, cp_ok, dp_ok;
  logic load_p0, hdr_vld_p0, no_data_p0, den_p0, err_p0;

  logic [63:0]          data_p1;
  logic                 hdr_vld_p1, no_data_p1, den_p1, err_p1;
  logic [ERR_CNT_W-1:0] err_cnt_p1;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == {ERR_CNT_W{1'b1}}) ? v : v + ERR_CNT_W'(1);
  endfunction

  assign is_with = (i_word[4:0] == OP_WITH_DATA);
  assign is_no   = (i_word[4:0] == OP_NO_DATA);
  assign tmo_hit = (tmo_cnt == TMO_LAST);

`ifdef SB_RX_PARITY_CHECK_EN
  // DP of the pending header, captured when the header is accepted.
  logic dp_p1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      dp_p1 <= 1'b0;
    else if (state == IDLE && i_word_valid && is_with)
      dp_p1 <= i_word[63];
  end

  assign cp_ok = (i_word[62] == ^i_word[61:0]);
  assign dp_ok = (dp_p1 == ^i_word);
`else
  assign cp_ok = 1'b1;
  assign dp_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_cnt_nxt;
    end
  end

  // Next-state logic; a word in the timeout cycle takes priority over timeout
  always_comb begin
    state_nxt   = state;
    tmo_cnt_nxt = tmo_cnt;
    case (state)
      IDLE: begin
        if (i_word_valid && cp_ok && is_with) begin
          state_nxt   = WAIT_DATA;
          tmo_cnt_nxt = '0;
        end
      end
      WAIT_DATA: begin
        if (i_word_valid || tmo_hit)
          state_nxt = IDLE;
        else
          tmo_cnt_nxt = tmo_cnt + 8'd1;
      end
    endcase
  end

  // Output decode (registered below for the one-cycle latency)
  always_comb begin
    load_p0    = 1'b0;
    hdr_vld_p0 = 1'b0;
    no_data_p0 = 1'b0;
    den_p0     = 1'b0;
    err_p0     = 1'b0;
    case (state)
      IDLE: begin
        if (i_word_valid) begin
          if (cp_ok && (is_with || is_no)) begin
            load_p0    = 1'b1;
            hdr_vld_p0 = 1'b1;
            no_data_p0 = is_no;
          end else begin
            err_p0 = 1'b1;
          end
        end
      end
      WAIT_DATA: begin
        if (i_word_valid) begin
          if (dp_ok) begin
            load_p0 = 1'b1;
            den_p0  = 1'b1;
          end else begin
            err_p0 = 1'b1;
          end
        end else if (tmo_hit) begin
          err_p0 = 1'b1;
        end
      end
    endcase
  end

  // Stage p1: registered bus, strobes and error counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_p1    <= '0;
      hdr_vld_p1 <= 1'b0;
      no_data_p1 <= 1'b0;
      den_p1     <= 1'b0;
      err_p1     <= 1'b0;
      err_cnt_p1 <= '0;
    end else begin
      if (load_p0)
        data_p1 <= i_word;
      hdr_vld_p1 <= hdr_vld_p0;
      no_data_p1 <= no_data_p0;
      den_p1     <= den_p0;
      err_p1     <= err_p0;
      if (err_p0)
        err_cnt_p1 <= sat_inc(err_cnt_p1);
    end
  end

  assign o_data                   = data_p1;
  assign o_header_is_valid_on_bus = hdr_vld_p1;
  assign o_msg_no_data            = no_data_p1;
  assign o_data_enable            = den_p1;
  assign o_err_pulse              = err_p1;
  assign o_err_cnt                = err_cnt_p1;
  assign o_busy                   = (state == WAIT_DATA);

endmodule

// File: tb/tb_sb_rx_packet_framer.sv
// Testbench for sb_rx_packet_framer. Each scenario pushes per-cycle stimulus
// and expected outputs into a scoreboard queue, then drains it cycle by cycle.
module tb_sb_rx_packet_framer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_word_valid;
  logic [63:0] i_word;
  logic [63:0] o_data;
  logic        o_header_is_valid_on_bus, o_data_enable, o_msg_no_data;
  logic        o_busy, o_err_pulse;
  logic [7:0]  o_err_cnt;

  sb_rx_packet_framer #(.TIMEOUT_CYCLES(16), .ERR_CNT_W(8)) dut (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_word_valid(i_word_valid),
    .i_word(i_word),
    .o_data(o_data),
    .o_header_is_valid_on_bus(o_header_is_valid_on_bus),
    .o_data_enable(o_data_enable),
    .o_msg_no_data(o_msg_no_data),
    .o_busy(o_busy),
    .o_err_pulse(o_err_pulse),
    .o_err_cnt(o_err_cnt)
  );

  always #5 i_clk = ~i_clk;

  // strobe vector order: {header_valid, msg_no_data, data_enable, err_pulse, busy}
  localparam logic [4:0] S_NONE   = 5'b00000;
  localparam logic [4:0] S_NODATA = 5'b11000;
  localparam logic [4:0] S_HDR    = 5'b10001;
  localparam logic [4:0] S_BUSY   = 5'b00001;
  localparam logic [4:0] S_DATA   = 5'b00100;
  localparam logic [4:0] S_ERR    = 5'b00010;

  typedef struct {
    string       name;
    logic        vld;
    logic [63:0] word;
    logic [4:0]  strb;
    logic [63:0] data;
    logic [7:0]  cnt;
  } exp_t;

  exp_t        sbq[$];
  int          nchk  = 0;
  int          npass = 0;
  logic [63:0] exp_data = '0;
  logic [7:0]  exp_cnt  = '0;

  function automatic logic [4:0] strobes();
    return {o_header_is_valid_on_bus, o_msg_no_data, o_data_enable, o_err_pulse, o_busy};
  endfunction

  function automatic logic [63:0] mk_hdr(input logic [4:0] op, input logic dp);
    logic [63:0] w;
    w        = {$urandom, $urandom};
    w[4:0]   = op;
    w[63]    = dp;
    w[62]    = ^w[61:0];
    return w;
  endfunction

  function automatic void bump_cnt();
    exp_cnt = (exp_cnt == 8'hFF) ? 8'hFF : exp_cnt + 8'd1;
  endfunction

  task automatic push(input string nm, input logic v, input logic [63:0] w, input logic [4:0] s);
    exp_t e;
    e.name = nm; e.vld = v; e.word = w; e.strb = s; e.data = exp_data; e.cnt = exp_cnt;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_word_valid = 1'b0; i_word = '0;
    #12;
    nchk++;
    if ({strobes(), o_data, o_err_cnt} !== '0)
      $display("FAIL reset outputs got strb=%b data=%h cnt=%0d want all 0", strobes(), o_data, o_err_cnt);
    else npass++;
    @(negedge i_clk); i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_no_data();
    exp_t e;
    logic [63:0] h = mk_hdr(5'b10010, 1'b0);
    exp_data = h; push("nodata_hdr", 1'b1, h, S_NODATA);
    push("nodata_hold", 1'b0, '0, S_NONE);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      i_word_valid = e.vld; i_word = e.word;
      @(posedge i_clk); #1; i_word_valid = 1'b0;
      nchk += 3;
      if (strobes() !== e.strb) $display("FAIL %s strobes got %b want %b", e.name, strobes(), e.strb); else npass++;
      if (o_data !== e.data) $display("FAIL %s data got %h want %h", e.name, o_data, e.data); else npass++;
      if (o_err_cnt !== e.cnt) $display("FAIL %s err_cnt got %0d want %0d", e.name, o_err_cnt, e.cnt); else npass++;
    end
  endtask

  task automatic test_with_data();
    exp_t e;
    logic [63:0] d = 64'hDEAD_BEEF_0000_0001;
    logic [63:0] h = mk_hdr(5'b11011, ^d);
    exp_data = h; push("wd_hdr", 1'b1, h, S_HDR);
    push("wd_wait1", 1'b0, '0, S_BUSY);
    push("wd_wait2", 1'b0, '0, S_BUSY);
    exp_data = d; push("wd_data", 1'b1, d, S_DATA);
    push("wd_after", 1'b0, '0, S_NONE);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      i_word_valid = e.vld; i_word = e.word;
      @(posedge i_clk); #1; i_word_valid = 1'b0;
      nchk += 3;
      if (strobes() !== e.strb) $display("FAIL %s strobes got %b want %b", e.name, strobes(), e.strb); else npass++;
      if (o_data !== e.data) $display("FAIL %s data got %h want %h", e.name, o_data, e.data); else npass++;
      if (o_err_cnt !== e.cnt) $display("FAIL %s err_cnt got %0d want %0d", e.name, o_err_cnt, e.cnt); else npass++;
    end
  endtask

  // late=0: no data word at all (timeout); late=1: data word in the timeout cycle
  task automatic test_timeout(input bit late);
    exp_t e;
    logic [63:0] d = {$urandom, $urandom};
    logic [63:0] h = mk_hdr(5'b11011, ^d);
    exp_data = h; push("tmo_hdr", 1'b1, h, S_HDR);
    for (int k = 1; k <= 15; k++) push("tmo_wait", 1'b0, '0, S_BUSY);
    if (late) begin
      exp_data = d; push("tmo_late_data", 1'b1, d, S_DATA);
    end else begin
      bump_cnt(); push("tmo_err", 1'b0, '0, S_ERR);
    end
    push("tmo_after", 1'b0, '0, S_NONE);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      i_word_valid = e.vld; i_word = e.word;
      @(posedge i_clk); #1; i_word_valid = 1'b0;
      nchk += 3;
      if (strobes() !== e.strb) $display("FAIL %s strobes got %b want %b", e.name, strobes(), e.strb); else npass++;
      if (o_data !== e.data) $display("FAIL %s data got %h want %h", e.name, o_data, e.data); else npass++;
      if (o_err_cnt !== e.cnt) $display("FAIL %s err_cnt got %0d want %0d", e.name, o_err_cnt, e.cnt); else npass++;
    end
  endtask

  task automatic test_bad_opcode();
    exp_t e;
    logic [4:0] ops [3] = '{5'b00000, 5'b11010, 5'b10011};
    foreach (ops[i]) begin
      bump_cnt(); push("badop", 1'b1, mk_hdr(ops[i], 1'b0), S_ERR);
    end
    push("badop_after", 1'b0, '0, S_NONE);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      i_word_valid = e.vld; i_word = e.word;
      @(posedge i_clk); #1; i_word_valid = 1'b0;
      nchk += 3;
      if (strobes() !== e.strb) $display("FAIL %s strobes got %b want %b", e.name, strobes(), e.strb); else npass++;
      if (o_data !== e.data) $display("FAIL %s data got %h want %h", e.name, o_data, e.data); else npass++;
      if (o_err_cnt !== e.cnt) $display("FAIL %s err_cnt got %0d want %0d", e.name, o_err_cnt, e.cnt); else npass++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [63:0] d  = {$urandom, $urandom};
    logic [63:0] h1 = mk_hdr(5'b10010, 1'b1);
    logic [63:0] h2 = mk_hdr(5'b11011, ^d);
    logic [63:0] h3 = mk_hdr(5'b10010, 1'b0);
    exp_data = h1; push("b2b_nodata1", 1'b1, h1, S_NODATA);
    exp_data = h2; push("b2b_hdr", 1'b1, h2, S_HDR);
    exp_data = d;  push("b2b_data", 1'b1, d, S_DATA);
    exp_data = h3; push("b2b_nodata2", 1'b1, h3, S_NODATA);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      i_word_valid = e.vld; i_word = e.word;
      @(posedge i_clk); #1; i_word_valid = 1'b0;
      nchk += 3;
      if (strobes() !== e.strb) $display("FAIL %s strobes got %b want %b", e.name, strobes(), e.strb); else npass++;
      if (o_data !== e.data) $display("FAIL %s data got %h want %h", e.name, o_data, e.data); else npass++;
      if (o_err_cnt !== e.cnt) $display("FAIL %s err_cnt got %0d want %0d", e.name, o_err_cnt, e.cnt); else npass++;
    end
  endtask

`ifdef SB_RX_PARITY_CHECK_EN
  task automatic test_parity();
    exp_t e;
    logic [63:0] d  = {$urandom, $urandom};
    logic [63:0] hb = mk_hdr(5'b10010, 1'b0);
    logic [63:0] h  = mk_hdr(5'b11011, ~(^d));
    hb[62] = ~hb[62];
    bump_cnt(); push("par_bad_cp", 1'b1, hb, S_ERR);
    exp_data = h; push("par_hdr", 1'b1, h, S_HDR);
    bump_cnt(); push("par_bad_dp", 1'b1, d, S_ERR);
    push("par_after", 1'b0, '0, S_NONE);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      i_word_valid = e.vld; i_word = e.word;
      @(posedge i_clk); #1; i_word_valid = 1'b0;
      nchk += 3;
      if (strobes() !== e.strb) $display("FAIL %s strobes got %b want %b", e.name, strobes(), e.strb); else npass++;
      if (o_data !== e.data) $display("FAIL %s data got %h want %h", e.name, o_data, e.data); else npass++;
      if (o_err_cnt !== e.cnt) $display("FAIL %s err_cnt got %0d want %0d", e.name, o_err_cnt, e.cnt); else npass++;
    end
  endtask
`endif

  task automatic test_reset_mid_packet();
    exp_t e;
    logic [63:0] h  = mk_hdr(5'b11011, 1'b0);
    logic [63:0] h2 = mk_hdr(5'b10010, 1'b1);
    i_word_valid = 1'b1; i_word = h;
    @(posedge i_clk); #1; i_word_valid = 1'b0;
    nchk++;
    if (o_busy !== 1'b1) $display("FAIL rst_mid busy_before got %b want 1", o_busy); else npass++;
    i_rst_n = 1'b0;
    #2;
    nchk++;
    if ({strobes(), o_data, o_err_cnt} !== '0)
      $display("FAIL rst_mid outputs got strb=%b data=%h cnt=%0d want all 0", strobes(), o_data, o_err_cnt);
    else npass++;
    @(negedge i_clk); i_rst_n = 1'b1;
    exp_cnt = '0; exp_data = '0;
    @(posedge i_clk); #1;
    exp_data = h2; push("rst_mid_next_hdr", 1'b1, h2, S_NODATA);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      i_word_valid = e.vld; i_word = e.word;
      @(posedge i_clk); #1; i_word_valid = 1'b0;
      nchk += 3;
      if (strobes() !== e.strb) $display("FAIL %s strobes got %b want %b", e.name, strobes(), e.strb); else npass++;
      if (o_data !== e.data) $display("FAIL %s data got %h want %h", e.name, o_data, e.data); else npass++;
      if (o_err_cnt !== e.cnt) $display("FAIL %s err_cnt got %0d want %0d", e.name, o_err_cnt, e.cnt); else npass++;
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    for (int i = 0; i < 300; i++) begin
      bump_cnt(); push("sat", 1'b1, mk_hdr(5'b00001, 1'b0), S_ERR);
    end
    push("sat_final", 1'b0, '0, S_NONE);
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      i_word_valid = e.vld; i_word = e.word;
      @(posedge i_clk); #1; i_word_valid = 1'b0;
      nchk += 3;
      if (strobes() !== e.strb) $display("FAIL %s strobes got %b want %b", e.name, strobes(), e.strb); else npass++;
      if (o_data !== e.data) $display("FAIL %s data got %h want %h", e.name, o_data, e.data); else npass++;
      if (o_err_cnt !== e.cnt) $display("FAIL %s err_cnt got %0d want %0d", e.name, o_err_cnt, e.cnt); else npass++;
    end
    nchk++;
    if (o_err_cnt !== 8'd255) $display("FAIL sat_255 err_cnt got %0d want 255", o_err_cnt); else npass++;
  endtask

  initial begin
    test_reset();
    test_no_data();
    test_with_data();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_bad_opcode();
    test_back_to_back();
`ifdef SB_RX_PARITY_CHECK_EN
    test_parity();
`endif
    test_reset_mid_packet();
    test_saturation();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
